// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and the
// default word/address widths that the engine and its memory must agree on.
package mem_copy_pkg;

    // Default data word width and address width (address space is 2**MEM_A words)
    localparam int MEM_W = 32;
    localparam int MEM_A = 12;

    // Copy engine states with a fixed 3-bit encoding.
    // VF is only reachable when MEM_COPY_VERIFY_EN is defined.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        VF   = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Address generator for the memory copy engine.
// Holds the captured source/destination bases and word count, the running
// word index, the wrap-around address adders and the last-word compare.
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int A = MEM_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture_i,   // accepted start: load bases/len, clear index
    input  logic         advance_i,   // current word finished: step the index
    input  logic [A-1:0] src_i,
    input  logic [A-1:0] dst_i,
    input  logic [A-1:0] len_i,
    output logic [A-1:0] src_addr_o,  // src + idx, modulo 2**A
    output logic [A-1:0] dst_addr_o,  // dst + idx, modulo 2**A
    output logic         last_o,      // the current word is the final one
    output logic         len_zero_o   // requested length (live input) is zero
);

    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] len_q, len_d;
    logic [A-1:0] idx_q, idx_d;

    // Next-state for the captured operands and the word index
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        idx_d = idx_q;
        if (capture_i) begin
            src_d = src_i;
            dst_d = dst_i;
            len_d = len_i;
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = idx_q + A'(1);
        end
    end

    // Operand and index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

    // Address adders truncate to A bits, so addresses wrap silently.
    // The length compare looks at the live input because the IDLE decision
    // is made in the same cycle the operands are captured.
    always_comb begin
        src_addr_o = src_q + idx_q;
        dst_addr_o = dst_q + idx_q;
        last_o     = ((idx_q + A'(1)) == len_q);
        len_zero_o = (len_i == '0);
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Memory copy engine: single-port bus initiator that copies len words from
// src to dst, one read and one write per word, always in ascending order.
// Optional feature: define MEM_COPY_VERIFY_EN to add a read-back verify
// state after every write, with a sticky err flag on mismatch.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int W = MEM_W,
    parameter int A = MEM_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] src,
    input  logic [A-1:0] dst,
    input  logic [A-1:0] len,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [A-1:0] mem_addr,
    output logic         mem_write,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    state_t       state_q, state_d;
    logic [W-1:0] buf_q, buf_d;

    logic         capture;
    logic         advance;
    logic [A-1:0] src_addr;
    logic [A-1:0] dst_addr;
    logic         last_word;
    logic         len_zero;

    // A start is only honoured in IDLE; anywhere else it is dropped
    assign capture = (state_q == IDLE) && start;

`ifdef MEM_COPY_VERIFY_EN
    // The index steps once the written word has been read back
    assign advance = (state_q == VF);
`else
    // The index steps as soon as the word has been written
    assign advance = (state_q == WR);
`endif

    mem_copy_addr_gen #(
        .A (A)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .capture_i  (capture),
        .advance_i  (advance),
        .src_i      (src),
        .dst_i      (dst),
        .len_i      (len),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .last_o     (last_word),
        .len_zero_o (len_zero)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = len_zero ? FIN : RD;
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
`ifdef MEM_COPY_VERIFY_EN
                state_d = VF;
`else
                state_d = last_word ? FIN : RD;
`endif
            end
`ifdef MEM_COPY_VERIFY_EN
            VF: begin
                state_d = last_word ? FIN : RD;
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the state register only so that an
    // asynchronous reset drops mem_write immediately
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = buf_q;
        case (state_q)
            RD: begin
                busy     = 1'b1;
                mem_addr = src_addr;
            end
            WR: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_addr;
            end
`ifdef MEM_COPY_VERIFY_EN
            VF: begin
                busy     = 1'b1;
                mem_addr = dst_addr;
            end
`endif
            FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Word buffer: holds the word read in RD until it is written (and verified)
    always_comb begin
        buf_d = buf_q;
        if (state_q == RD) begin
            buf_d = mem_rdata;
        end
    end

    // Word buffer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

`ifdef MEM_COPY_VERIFY_EN
    logic err_q, err_d;

    // Sticky verify flag: cleared by an accepted start, set on any read-back mismatch
    always_comb begin
        err_d = err_q;
        if (capture) begin
            err_d = 1'b0;
        end else if ((state_q == VF) && (mem_rdata != buf_q)) begin
            err_d = 1'b1;
        end
    end

    // Verify flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without read-back verification there is nothing to flag
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine with a behavioural single-port memory
// (combinational read, posedge write). Define MEM_COPY_VERIFY_EN to also
// exercise the read-back verify path with a dropped write at address 101.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int W = MEM_W;
    localparam int A = MEM_A;
`ifdef MEM_COPY_VERIFY_EN
    localparam int STEP = 3;
`else
    localparam int STEP = 2;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A-1:0] len;
    logic         busy;
    logic         done;
    logic         err;
    logic [A-1:0] mem_addr;
    logic         mem_write;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    // bench-side memory preload port and write-drop fault injection
    logic         tb_we;
    logic [A-1:0] tb_waddr;
    logic [W-1:0] tb_wdata;
    logic         drop_en;

    logic [W-1:0] mem [0:(1<<A)-1];

    int n_checks;
    int n_errors;
    int done_cnt;
    int wr_cnt;

    mem_copy_engine #(.W(W), .A(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: combinational read, engine write has priority over bench preload
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) begin
            if (!(drop_en && mem_addr == A'(101)))
                mem[mem_addr] <= mem_wdata;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    // pulse and write-cycle counters, sampled mid-cycle
    initial begin
        done_cnt = 0;
        wr_cnt   = 0;
    end
    always @(negedge clk) begin
        if (done)      done_cnt <= done_cnt + 1;
        if (mem_write) wr_cnt   <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic poke(input int a, input int d);
        tb_we    = 1'b1;
        tb_waddr = A'(a);
        tb_wdata = W'(d);
        @(posedge clk); #1;
        tb_we    = 1'b0;
    endtask

    // start a copy, return cycles from the accepting edge to the done pulse
    task automatic run_copy(input int s, input int d, input int l, output int lat);
        src = A'(s); dst = A'(d); len = A'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, (l != 0) ? 32'd1 : 32'd0);
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;   // FIN -> IDLE
    endtask

    int lat;
    int d0;
    int w0;
    int n;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0; drop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_done",  {31'd0, done}, 0);
        chk("rst_err",   {31'd0, err}, 0);
        chk("rst_mwr",   {31'd0, mem_write}, 0);
        chk("rst_maddr", {20'd0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: basic copy of four words
        poke(10, 1); poke(11, 2); poke(12, 3); poke(13, 4);
        run_copy(10, 100, 4, lat);
        chk("t1_latency", lat, STEP*4+1);
        chk("t1_m100", mem[100], 1);
        chk("t1_m101", mem[101], 2);
        chk("t1_m102", mem[102], 3);
        chk("t1_m103", mem[103], 4);
        chk("t1_err",  {31'd0, err}, 0);

        // 2: zero length
        poke(5, 55); poke(6, 66);
        w0 = wr_cnt;
        run_copy(5, 6, 0, lat);
        chk("t2_latency", lat, 1);
        chk("t2_no_write", wr_cnt - w0, 0);
        chk("t2_m6", mem[6], 66);

        // 3: source wraps past the top of the address space into the destination
        poke(4094, 7); poke(4095, 8); poke(0, 9); poke(1, 10);
        run_copy(4094, 0, 4, lat);
        chk("t3_m0", mem[0], 7);
        chk("t3_m1", mem[1], 8);
        chk("t3_m2", mem[2], 7);
        chk("t3_m3", mem[3], 8);

        // 4: overlapping forward copy smears the first word
        poke(20, 5); poke(21, 6); poke(22, 7);
        run_copy(20, 21, 3, lat);
        chk("t4_m21", mem[21], 5);
        chk("t4_m22", mem[22], 5);
        chk("t4_m23", mem[23], 5);

        // 5a: start while busy is ignored
        poke(30, 11); poke(31, 12); poke(32, 13); poke(33, 14); poke(300, 77);
        d0 = done_cnt;
        src = A'(30); dst = A'(200); len = A'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        src = A'(10); dst = A'(300); len = A'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src = '0; dst = '0; len = '0;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_single_done", done_cnt - d0, 1);
        chk("t5_m200", mem[200], 11);
        chk("t5_m203", mem[203], 14);
        chk("t5_m300", mem[300], 77);

        // 5b: reset in the write cycle of word 2
        src = A'(30); dst = A'(400); len = A'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(mem_write && mem_addr == A'(402)) && n < 50) begin @(negedge clk); n++; end
        chk("t5_found_wr2", {31'd0, (n < 50)}, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_mwr",  {31'd0, mem_write}, 0);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) begin @(posedge clk); #1; end
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle_busy", {31'd0, busy}, 0);

`ifdef MEM_COPY_VERIFY_EN
        // 6: dropped write is caught by read-back, next start clears err
        poke(101, 99);
        drop_en = 1'b1;
        run_copy(10, 100, 4, lat);
        drop_en = 1'b0;
        chk("t6_latency", lat, 13);
        chk("t6_err_set", {31'd0, err}, 1);
        chk("t6_m101_dropped", mem[101], 99);
        chk("t6_m103", mem[103], 4);
        run_copy(5, 6, 0, lat);
        chk("t6_err_cleared", {31'd0, err}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
